mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: none; all widths fixed at 32-bit address/data, 4-bit byte enable.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 instr_mem_read  input  1  instruction-port read request, held high until instr_mem_resp.
REQ-005 instr_mem_address  input  32  instruction-port word address.
REQ-006 instr_mem_rdata  output  32  instruction-port read data, valid when instr_mem_resp=1.
REQ-007 instr_mem_resp  output  1  instruction-port completion pulse.
REQ-008 data_mem_read / data_mem_write  input  1 each  data-port request, held until data_mem_resp.
REQ-009 data_mem_address / data_mem_wdata  input  32 each  data-port address / write data.
REQ-010 d_mbe  input  4  data-port byte enables for writes.
REQ-011 data_mem_rdata  output  32  data-port read data, valid when data_mem_resp=1.
REQ-012 data_mem_resp  output  1  data-port completion pulse.
REQ-013 pmem_read / pmem_write  output  1 each  backing-memory request, held until pmem_resp.
REQ-014 pmem_address / pmem_wdata  output  32 each; pmem_mbe  output  4.
REQ-015 pmem_rdata  input  32; pmem_resp  input  1  backing-memory completion.

Function
REQ-016 The block SHALL be a four-state FSM: IDLE, SERVE_I, SERVE_D, DONE.
REQ-017 IDLE: pending = instr_mem_read for I, (data_mem_read|data_mem_write) for D; none pending -> stay IDLE.
REQ-018 Only one pending -> grant it (SERVE_I or SERVE_D) next edge.
REQ-019 Both pending -> grant the port NOT recorded in last_grant; last_grant resets to I, so first tie goes to D.
REQ-020 On grant, address, wdata, mbe and op (read/write) SHALL be latched; pmem outputs driven only from latched values.
REQ-021 data_mem_read and data_mem_write both high at grant -> write SHALL win.
REQ-022 Instruction grants SHALL always be reads with pmem_mbe=4'b1111.
REQ-023 SERVE_x: pmem_read or pmem_write held high (never both) until the cycle pmem_resp=1; then -> DONE, last_grant updated to x.
REQ-024 On the pmem_resp edge, read data SHALL be captured into the granted port's rdata register; writes leave data_mem_rdata unchanged.
REQ-025 DONE: granted port's resp=1 for exactly one cycle, pmem_read=pmem_write=0, no new grant; -> IDLE next edge.
REQ-026 Latency: request seen in IDLE at edge N, pmem response at edge N+k -> port resp high during cycle after edge N+k; minimum 3 cycles request-to-resp (k=1).
REQ-027 rdata outputs SHALL hold their value until the next read completion on the same port.
REQ-028 Requester dropping its request mid-service SHALL NOT abort the pmem transaction; resp is still pulsed.
REQ-029 pmem_resp while in IDLE or DONE SHALL be ignored.
REQ-030 Non-granted port's resp SHALL be 0 in every state; both resps never high together.
REQ-031 pmem outputs SHALL be 0 in IDLE and DONE.

Reset
REQ-032 rst=0 SHALL immediately (asynchronously) force state=IDLE, last_grant=I, all outputs and rdata registers to 0.
REQ-033 Reset during SERVE_x SHALL abandon the transaction; no resp SHALL be generated for it after rst returns high.
REQ-034 First grant SHALL be evaluated on the first rising clk edge after rst returns high.

Verification
REQ-035 I-read 0x0000_0060, pmem returns 0x0000_0013 with k=1 -> instr_mem_resp one cycle, instr_mem_rdata=0x0000_0013, exactly 3 cycles after request.
REQ-036 Simultaneous I-read 0x100 and D-read 0x200 after reset -> pmem sees 0x200 first, then 0x100; data_mem_resp precedes instr_mem_resp; both rdata correct.
REQ-037 Both ports continuously requesting for 6 transactions -> grants alternate D,I,D,I,D,I; no starvation.
REQ-038 D-write 0x300, wdata 0xDEAD_BEEF, d_mbe=4'b0011, read and write both high -> pmem_write=1, pmem_read=0, pmem_mbe=4'b0011; data_mem_rdata unchanged.
REQ-039 pmem_resp delayed 10 cycles with address changing on the port mid-wait -> pmem_address stays at latched value; single resp after response.
REQ-040 rst pulsed low during SERVE_D with pmem_resp arriving after reset release -> outputs 0 during reset, no data_mem_resp, FSM in IDLE and stray pmem_resp ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between an instruction read port and a data read/write port.
// Ties alternate away from the last-served port; a request is latched at grant so requesters may change or drop inputs mid-service.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_mem_read,
    input  logic [31:0] instr_mem_address,
    output logic [31:0] instr_mem_rdata,
    output logic        instr_mem_resp,
    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    input  logic [3:0]  d_mbe,
    output logic [31:0] data_mem_rdata,
    output logic        data_mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_wdata,
    output logic [3:0]  pmem_mbe,
    input  logic [31:0] pmem_rdata,
    input  logic        pmem_resp
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_e;

    state_e      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic [3:0]  mbe_q, mbe_d;
    logic        i_pend, d_pend, grant_d, serving;

    assign i_pend  = instr_mem_read;
    assign d_pend  = data_mem_read | data_mem_write;
    // last_d_q is 0 after reset, so the first tie goes to the data port
    assign grant_d = d_pend & (~i_pend | ~last_d_q);
    assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mbe_d     = mbe_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = SERVE_D;
                    write_d = data_mem_write;
                    addr_d  = data_mem_address;
                    wdata_d = data_mem_wdata;
                    mbe_d   = d_mbe;
                end else if (i_pend) begin
                    state_d = SERVE_I;
                    write_d = 1'b0;
                    addr_d  = instr_mem_address;
                    wdata_d = '0;
                    mbe_d   = 4'hf;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d  = DONE;
                    last_d_d = state_q == SERVE_D;
                    i_rdata_d = (state_q == SERVE_I) ? pmem_rdata : i_rdata_q;
                    d_rdata_d = (state_q == SERVE_D && !write_q) ? pmem_rdata : d_rdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mbe_q     <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mbe_q     <= mbe_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // in DONE, last_d_q already names the port just served
    assign instr_mem_resp  = (state_q == DONE) & ~last_d_q;
    assign data_mem_resp   = (state_q == DONE) & last_d_q;
    assign instr_mem_rdata = i_rdata_q;
    assign data_mem_rdata  = d_rdata_q;
    assign pmem_read       = serving & ~write_q;
    assign pmem_write      = serving & write_q;
    assign pmem_address    = serving ? addr_q : '0;
    assign pmem_wdata      = serving ? wdata_q : '0;
    assign pmem_mbe        = serving ? mbe_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven vectors plus corner-case sequences, checked by a pmem/response scoreboard.
module tb_mem_arbiter;
    logic        clk = 0, rst = 1;
    logic        instr_mem_read = 0, data_mem_read = 0, data_mem_write = 0;
    logic [31:0] instr_mem_address = 0, data_mem_address = 0, data_mem_wdata = 0;
    logic [3:0]  d_mbe = 0;
    logic [31:0] instr_mem_rdata, data_mem_rdata, pmem_address, pmem_wdata;
    logic        instr_mem_resp, data_mem_resp, pmem_read, pmem_write;
    logic [3:0]  pmem_mbe;
    logic [31:0] pmem_rdata = 0;
    logic        pmem_resp = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .instr_mem_read(instr_mem_read), .instr_mem_address(instr_mem_address),
        .instr_mem_rdata(instr_mem_rdata), .instr_mem_resp(instr_mem_resp),
        .data_mem_read(data_mem_read), .data_mem_write(data_mem_write),
        .data_mem_address(data_mem_address), .data_mem_wdata(data_mem_wdata), .d_mbe(d_mbe),
        .data_mem_rdata(data_mem_rdata), .data_mem_resp(data_mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_mbe(pmem_mbe), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct {logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mbe; logic mchk;} txn_t;
    typedef struct {logic port; logic [31:0] rdata;} rsp_t;
    typedef struct {logic i_rd; logic [31:0] i_addr; logic d_rd; logic d_wr; logic [31:0] d_addr;
                    logic [31:0] d_wdata; logic [3:0] mbe; int lat; logic d_first;} vec_t;

    txn_t        exp_txn[$];
    rsp_t        exp_rsp[$];
    txn_t        cur;
    rsp_t        r;
    vec_t        vecs[7];
    int          checks = 0, errors = 0, lat = 0, cnt = 0;
    logic [31:0] i_model = 0, d_model = 0, man_rdata = 0;
    logic        auto_en = 1, man_resp = 0, act_prev = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h60) ? 32'h13 : {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected none", name, act);
    endtask

    task automatic push_i(input logic [31:0] a);
        exp_txn.push_back('{1'b0, a, 32'h0, 4'hf, 1'b1});
        i_model = mem_data(a);
        exp_rsp.push_back('{1'b0, i_model});
    endtask

    task automatic push_d(input logic wr, input logic [31:0] a, input logic [31:0] w, input logic [3:0] m);
        exp_txn.push_back('{wr, a, w, m, wr});
        if (!wr) d_model = mem_data(a);
        exp_rsp.push_back('{1'b1, d_model});
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_rdata"}, instr_mem_rdata | data_mem_rdata, 32'h0);
        check({name, "_pmem"}, pmem_address | pmem_wdata | 32'(pmem_mbe), 32'h0);
        check({name, "_ctrl"}, 32'({pmem_read, pmem_write, instr_mem_resp, data_mem_resp}), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        #1 check_outputs_zero("reset");
        i_model = 0;
        d_model = 0;
        @(negedge clk);
        rst = 1;
    endtask

    // waits for n completions, dropping each port's request once it is answered
    task automatic serve(input int n);
        int got = 0;
        int t = 0;
        while (got < n && t < 200) begin
            @(negedge clk);
            t++;
            if (instr_mem_resp) begin instr_mem_read = 0; got++; end
            if (data_mem_resp) begin data_mem_read = 0; data_mem_write = 0; got++; end
        end
        check("resp_count", got, n);
        repeat (2) @(negedge clk);
    endtask

    // backing memory: answers lat cycles after a request appears, or replays manual values
    always @(negedge clk) begin
        if (!auto_en) begin
            pmem_resp = man_resp;
            pmem_rdata = man_rdata;
            cnt = 0;
        end else if ((pmem_read || pmem_write) && !pmem_resp) begin
            if (cnt >= lat) begin
                pmem_resp = 1;
                pmem_rdata = pmem_write ? 32'hBAD0_BAD0 : mem_data(pmem_address);
                cnt = 0;
            end else cnt++;
        end else begin
            pmem_resp = 0;
            cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) act_prev = 0;
        else begin
            check("rd_and_wr", 32'(pmem_read & pmem_write), 32'h0);
            check("both_resp", 32'(instr_mem_resp & data_mem_resp), 32'h0);
            if (pmem_read || pmem_write) begin
                if (!act_prev) begin
                    if (exp_txn.size() == 0) unexpected("pmem_txn", pmem_address);
                    else cur = exp_txn.pop_front();
                end
                check("pmem_write", 32'(pmem_write), 32'(cur.wr));
                check("pmem_address", pmem_address, cur.addr);
                if (cur.wr) check("pmem_wdata", pmem_wdata, cur.wdata);
                if (cur.mchk) check("pmem_mbe", 32'(pmem_mbe), 32'(cur.mbe));
            end else check("pmem_idle_zero", pmem_address | pmem_wdata | 32'(pmem_mbe), 32'h0);
            if (instr_mem_resp || data_mem_resp) begin
                if (exp_rsp.size() == 0) unexpected("resp", 32'({instr_mem_resp, data_mem_resp}));
                else begin
                    r = exp_rsp.pop_front();
                    check("resp_port", 32'(data_mem_resp), 32'(r.port));
                    check("rdata", data_mem_resp ? data_mem_rdata : instr_mem_rdata, r.rdata);
                end
            end
            act_prev = pmem_read || pmem_write;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, got, di, ii;
        vecs[0] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, 4'hf, 0, 1'b1};
        vecs[1] = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011, 2, 1'b0};
        vecs[3] = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 4'hf, 1, 1'b0};
        vecs[4] = '{1'b1, 32'h44, 1'b0, 1'b1, 32'h88, 32'h1122_3344, 4'b1100, 0, 1'b0};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 4'hf, 3, 1'b0};
        vecs[6] = '{1'b1, 32'h600, 1'b1, 1'b0, 32'h700, 32'h0, 4'hf, 1, 1'b0};

        #1 rst = 0;
        #1 check_outputs_zero("por");
        @(negedge clk);
        rst = 1;
        instr_mem_read = 1;
        instr_mem_address = 32'h60;
        push_i(32'h60);
        n = 0;
        do begin @(negedge clk); n++; end while (!instr_mem_resp && n < 20);
        check("latency_cycle", n + 1, 3);
        instr_mem_read = 0;
        repeat (2) @(negedge clk);

        do_reset();
        foreach (vecs[i]) begin
            lat = vecs[i].lat;
            instr_mem_read = vecs[i].i_rd;
            instr_mem_address = vecs[i].i_addr;
            data_mem_read = vecs[i].d_rd;
            data_mem_write = vecs[i].d_wr;
            data_mem_address = vecs[i].d_addr;
            data_mem_wdata = vecs[i].d_wdata;
            d_mbe = vecs[i].mbe;
            if (vecs[i].d_first && (vecs[i].d_rd || vecs[i].d_wr))
                push_d(vecs[i].d_wr, vecs[i].d_addr, vecs[i].d_wdata, vecs[i].mbe);
            if (vecs[i].i_rd) push_i(vecs[i].i_addr);
            if (!vecs[i].d_first && (vecs[i].d_rd || vecs[i].d_wr))
                push_d(vecs[i].d_wr, vecs[i].d_addr, vecs[i].d_wdata, vecs[i].mbe);
            serve(int'(vecs[i].i_rd) + int'(vecs[i].d_rd | vecs[i].d_wr));
        end

        do_reset();
        lat = 1;
        for (int k = 0; k < 3; k++) begin
            push_d(1'b0, 32'h1000 + 32'(4 * k), 32'h0, 4'hf);
            push_i(32'h2000 + 32'(4 * k));
        end
        data_mem_read = 1;
        data_mem_address = 32'h1000;
        instr_mem_read = 1;
        instr_mem_address = 32'h2000;
        di = 0;
        ii = 0;
        n = 0;
        while (di + ii < 6 && n < 200) begin
            @(negedge clk);
            n++;
            if (data_mem_resp) begin
                di++;
                if (di < 3) data_mem_address = 32'h1000 + 32'(4 * di);
                else data_mem_read = 0;
            end
            if (instr_mem_resp) begin
                ii++;
                if (ii < 3) instr_mem_address = 32'h2000 + 32'(4 * ii);
                else instr_mem_read = 0;
            end
        end
        check("alternate_count", di * 16 + ii, 3 * 16 + 3);
        repeat (2) @(negedge clk);

        lat = 9;
        data_mem_read = 1;
        data_mem_address = 32'h400;
        push_d(1'b0, 32'h400, 32'h0, 4'hf);
        got = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t == 3) data_mem_address = 32'h999;
            if (data_mem_resp) begin got++; data_mem_read = 0; end
        end
        check("delayed_resp_count", got, 1);

        auto_en = 0;
        man_resp = 0;
        data_mem_read = 1;
        data_mem_address = 32'h800;
        exp_txn.push_back('{1'b0, 32'h800, 32'h0, 4'hf, 1'b0});
        n = 0;
        do begin @(negedge clk); n++; end while (!pmem_read && n < 10);
        check("serve_d_started", 32'(pmem_read), 32'h1);
        #2 rst = 0;
        #1 check_outputs_zero("mid_reset");
        i_model = 0;
        d_model = 0;
        data_mem_read = 0;
        @(negedge clk);
        rst = 1;
        #2 man_resp = 1;
        man_rdata = 32'h7777_7777;
        got = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            #2 man_resp = 0;
            if (data_mem_resp || instr_mem_resp) got++;
        end
        check("stray_resp_count", got, 0);
        check("post_reset_idle", 32'({pmem_read, pmem_write}), 32'h0);
        check("post_reset_rdata", data_mem_rdata, 32'h0);
        auto_en = 1;

        check("txn_queue_left", exp_txn.size(), 0);
        check("rsp_queue_left", exp_rsp.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
